z80_bus_arbiter: RTL and testbench
==================================

// Module: z80_bus_arbiter
// PURPOSE
//  Shares the Z80 system bus (ROM/RAM behind the MMU bank logic) between the CPU and NREQ
//  external bus masters (DMA, serial loader, video fetch) via the Z80 BUSREQ/BUSACK protocol.
//  Round-robin among requesters; enforces max hold time and guaranteed CPU slot between grants.
//  Sits beside the MMU on the fast master clock that also feeds the CPU clock divider.
// PARAMETERS
//  NREQ      2     number of external requesters (1..4)
//  HOLD_W    8     width of hold / gap counters
//  MAX_HOLD  200   max clk cycles a grant may last; 0 = unlimited
//  CPU_SLOT  16    min clk cycles busreq_n stays high after a release
//  ACK_TO    1023  max clk cycles waiting for BUSACK before abort (10-bit counter)
// PORTS
//  clk       in   1     master clock (not divided CPU clock)
//  reset     in   1     asynchronous, active-low reset
//  busack_n  in   1     Z80 BUSACK, asynchronous to clk
//  req       in   NREQ  level request per master, held high while bus wanted
//  en_mask   in   NREQ  1 = requester enabled; masked req ignored / revoked
//  busreq_n  out  1     Z80 BUSREQ, active low
//  gnt       out  NREQ  one-hot grant; master may drive bus only while its bit is high
//  cur_id    out  2     index of current/last granted requester
//  busy      out  1     high in any state other than IDLE
//  hold_err  out  1     1-cycle pulse: grant revoked by MAX_HOLD
//  ack_err   out  1     1-cycle pulse: BUSACK timeout, request aborted
// BEHAVIOUR
//  - Reset (async, active-low): busreq_n=1, gnt=0, cur_id=NREQ-1, busy=0, errs=0, state IDLE,
//    counters 0. Reset mid-grant drops gnt and busreq_n immediately, no turnaround.
//  - busack_n passes through 2-flop synchronizer (reset value 1); FSM uses ack_s only.
//  - Eligible set E = req & en_mask. Winner = first set bit of E searching from cur_id+1 mod NREQ.
//  - IDLE: E!=0 -> REQ, latch winner into cur_id, busreq_n=0 on the same edge.
//  - REQ: busreq_n=0, ack counter runs. ack_s==0 -> GRANT, gnt[cur_id]=1 on that edge
//    (≥3 clk from BUSACK pin to gnt). Winner's req or mask bit drops -> TURN (no grant).
//    Counter reaches ACK_TO -> ack_err pulse, -> GAP (busreq_n=1).
//  - GRANT: gnt one-hot, hold counter increments each clk. Exit when req[cur_id]=0,
//    en_mask[cur_id]=0, or counter==MAX_HOLD-1 (MAX_HOLD!=0; hold_err pulses). Exit edge clears gnt.
//  - TURN: exactly 1 clk, gnt=0, busreq_n still 0 (bus driver turnaround) -> GAP.
//  - GAP: busreq_n=1, gap counter counts CPU_SLOT clks AND waits ack_s==1; then -> IDLE.
//    New requests are not serviced in GAP (CPU keeps ≥CPU_SLOT clks of bus).
//  - Simultaneous req: round-robin from cur_id+1; a continuously requesting master
//    cannot win twice while another eligible one waits.
//  - Requests arriving during GRANT wait; no preemption except mask/timeout.
//  - Counters saturate, never wrap; cleared on state entry.
//  - gnt never has >1 bit set; gnt!=0 only in GRANT; busreq_n=1 only in IDLE/GAP.
// STRUCTURE
//  - mintz80_pkg: arb_state_t enum {IDLE,REQ,GRANT,TURN,GAP}, ACK_TO width constant,
//    NREQ_MAX=4.
//  - Sub-module sync2: 2-flop synchronizer, async active-low reset, parameterised reset value.
//  - Round-robin picker as a function in the package; FSM, counters, outputs here.
// TESTING
//  1 Reset: assert reset mid-GRANT -> gnt=0, busreq_n=1 same cycle; all outputs at reset values.
//  2 Single req[0]=1, BUSACK low 5 clk after busreq_n -> gnt=01 three clk after BUSACK falls;
//    req drop -> gnt=0, busreq_n rises 1 clk later, held high 16 clk.
//  3 req=11 held constant -> grants alternate 01,10,01 with CPU_SLOT gap each; cur_id toggles.
//  4 MAX_HOLD=200, req[1] held -> gnt[1] drops after exactly 200 clk, hold_err one pulse.
//  5 busack_n held high -> ack_err pulse after 1023 clk in REQ, busreq_n=1, no gnt ever.
//  6 en_mask[0] cleared during GRANT of 0 -> gnt=00 next edge, TURN, GAP; masked req ignored.

Source files
------------

// File: rtl/z80_bus_arbiter_pkg.sv
// Shared types and helpers for the Z80 bus arbiter.
//   arb_state_t : arbiter FSM states
//   NREQ_MAX    : largest supported number of external requesters
//   ACK_W       : width of the BUSACK wait counter
//   rr_pick()   : round-robin winner search starting after the last winner
package z80_bus_arbiter_pkg;

  localparam int unsigned NREQ_MAX = 4;
  localparam int unsigned ACK_W    = 10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    TURN,
    GAP
  } arb_state_t;

  // First set bit of elig, searching last+1, last+2, ... modulo n. The search wraps
  // onto last itself, so a lone requester can win again.
  function automatic logic [1:0] rr_pick(input logic [NREQ_MAX-1:0] elig,
                                         input logic [1:0]          last,
                                         input int unsigned         n);
    logic [1:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ_MAX; i++) begin
      idx = (32'(last) + i) % n;
      if (!found && (i <= n) && elig[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/z80_bus_arbiter_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   reset : asynchronous, active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk of latency)
module z80_bus_arbiter_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares the Z80 system bus between the CPU and NREQ external masters using BUSREQ/BUSACK.
// Round-robin among requesters, bounded hold time, and a guaranteed CPU slot between grants.
//   clk      : master clock (not the divided CPU clock)
//   reset    : asynchronous, active-low reset
//   busack_n : Z80 BUSACK, asynchronous to clk
//   req      : level request per master
//   en_mask  : 1 = requester enabled; masked requests are ignored or revoked
//   busreq_n : Z80 BUSREQ, active low
//   gnt      : one-hot grant
//   cur_id   : index of current / last granted requester
//   busy     : high in any state other than IDLE
//   hold_err : 1-cycle pulse, grant revoked by MAX_HOLD
//   ack_err  : 1-cycle pulse, BUSACK timeout
module z80_bus_arbiter
  import z80_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned HOLD_W   = 8,
  parameter int unsigned MAX_HOLD = 200,
  parameter int unsigned CPU_SLOT = 16,
  parameter int unsigned ACK_TO   = 1023
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            busack_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] en_mask,
  output logic            busreq_n,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      cur_id,
  output logic            busy,
  output logic            hold_err,
  output logic            ack_err
);

  arb_state_t          state_q;
  logic [HOLD_W-1:0]   cnt_q;     // hold count in GRANT, gap count in GAP
  logic [ACK_W-1:0]    ack_q;     // BUSACK wait count in REQ
  logic                ack_s;

  logic [NREQ-1:0]     elig;
  logic [NREQ_MAX-1:0] elig_ext;
  logic [NREQ-1:0]     cur_onehot;
  logic [1:0]          winner;
  logic                cur_ok;
  logic                hold_done;
  logic                gap_done;
  logic                ack_done;
  logic [HOLD_W-1:0]   cnt_inc;
  logic [ACK_W-1:0]    ack_inc;

  z80_bus_arbiter_sync2 #(
    .RESET_VAL (1'b1)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (busack_n),
    .q     (ack_s)
  );

  always_comb begin
    elig       = req & en_mask;
    elig_ext   = NREQ_MAX'(elig);
    winner     = rr_pick(elig_ext, cur_id, NREQ);
    cur_onehot = NREQ'(1) << cur_id;
    cur_ok     = |(elig & cur_onehot);
    // Counters saturate rather than wrap.
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    ack_inc    = (&ack_q) ? ack_q : ack_q + 1'b1;
    hold_done  = (MAX_HOLD != 0) && ((32'(cnt_q) + 32'd1) >= MAX_HOLD);
    gap_done   = (32'(cnt_q) + 32'd1) >= CPU_SLOT;
    ack_done   = (32'(ack_q) + 32'd1) >= ACK_TO;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busreq_n <= 1'b1;
      gnt      <= '0;
      cur_id   <= 2'(NREQ - 1);
      busy     <= 1'b0;
      hold_err <= 1'b0;
      ack_err  <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
    end else begin
      hold_err <= 1'b0;
      ack_err  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|elig) begin
            state_q  <= REQ;
            cur_id   <= winner;
            busreq_n <= 1'b0;
            busy     <= 1'b1;
            ack_q    <= '0;
          end
        end
        REQ: begin
          ack_q <= ack_inc;
          // A winner that withdraws before BUSACK is never granted.
          if (!cur_ok) begin
            state_q <= TURN;
          end else if (!ack_s) begin
            state_q <= GRANT;
            gnt     <= cur_onehot;
            cnt_q   <= '0;
          end else if (ack_done) begin
            state_q  <= GAP;
            busreq_n <= 1'b1;
            ack_err  <= 1'b1;
            cnt_q    <= '0;
          end
        end
        GRANT: begin
          cnt_q <= cnt_inc;
          if (!cur_ok || hold_done) begin
            state_q  <= TURN;
            gnt      <= '0;
            hold_err <= cur_ok;  // still wanted, so the limit revoked it
          end
        end
        TURN: begin
          // One cycle with gnt low but BUSREQ still held lets the master's drivers release.
          state_q  <= GAP;
          busreq_n <= 1'b1;
          cnt_q    <= '0;
        end
        GAP: begin
          cnt_q <= cnt_inc;
          if (gap_done && ack_s) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Self-checking bench for z80_bus_arbiter: reset values, a round-robin vector table,
// directed multi-cycle sequences, and a randomized run checked by a rule-based model.
module tb_z80_bus_arbiter;

  localparam int unsigned NREQ     = 2;
  localparam int unsigned MAX_HOLD = 200;
  localparam int unsigned CPU_SLOT = 16;
  localparam int unsigned ACK_TO   = 1023;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       busack_n = 1'b1;
  logic [1:0] req      = 2'b00;
  logic [1:0] en_mask  = 2'b11;
  logic       busreq_n;
  logic [1:0] gnt;
  logic [1:0] cur_id;
  logic       busy;
  logic       hold_err;
  logic       ack_err;

  int errors = 0;
  int checks = 0;

  // CPU responder and model state
  bit  auto_ack    = 1'b0;
  int  ack_rmax    = 0;
  int  ack_wait    = 0;
  int  ack_low_cnt = 0;
  bit  mon_en      = 1'b0;
  logic       prev_busreq_n = 1'b1;
  logic [1:0] prev_gnt      = 2'b00;
  int  last_id   = NREQ - 1;
  int  high_cnt  = 1000;
  int  grant_len = 0;
  int  n_grants  = 0;

  always #5 clk = ~clk;

  z80_bus_arbiter #(
    .NREQ     (NREQ),
    .HOLD_W   (8),
    .MAX_HOLD (MAX_HOLD),
    .CPU_SLOT (CPU_SLOT),
    .ACK_TO   (ACK_TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .busack_n (busack_n),
    .req      (req),
    .en_mask  (en_mask),
    .busreq_n (busreq_n),
    .gnt      (gnt),
    .cur_id   (cur_id),
    .busy     (busy),
    .hold_err (hold_err),
    .ack_err  (ack_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next owner: walk the requesters in order starting just after the last owner.
  function automatic int rr_ref(input logic [1:0] e, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (e[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return last;
  endfunction

  task automatic monitor();
    logic [1:0] e;
    int         w;
    e = req & en_mask;
    check("gnt_onehot", $countones(gnt) <= 1, 1);
    check("busy_when_active", busy | (busreq_n & (gnt == 2'b00)), 1);
    check("ack_err_quiet", ack_err, 0);
    if (busreq_n) begin
      check("gnt_when_released", gnt, 0);
      high_cnt++;
    end
    if (prev_busreq_n && !busreq_n) begin
      w = rr_ref(e, last_id);
      check("rr_winner", cur_id, w);
      check("cpu_slot", high_cnt >= CPU_SLOT + 1, 1);
      last_id  = w;
      high_cnt = 0;
    end
    if (gnt != 2'b00) begin
      check("gnt_id", gnt, 2'b01 << last_id);
      check("gnt_eligible", e[last_id], 1);
      if (prev_gnt == 2'b00) begin
        check("ack_sync_latency", ack_low_cnt >= 3, 1);
        grant_len = 1;
        n_grants++;
      end else begin
        grant_len++;
      end
      check("hold_limit", grant_len <= MAX_HOLD, 1);
      check("hold_err_quiet", hold_err, 0);
    end else if (prev_gnt != 2'b00) begin
      check("release_reason", !e[last_id] || (grant_len == MAX_HOLD), 1);
      check("hold_err_pulse", hold_err, e[last_id]);
    end else begin
      check("hold_err_quiet", hold_err, 0);
    end
  endtask

  // One clock: sample at the falling edge, run the model, then let the CPU respond.
  task automatic cyc();
    @(negedge clk);
    if (!busack_n) ack_low_cnt++;
    else ack_low_cnt = 0;
    if (mon_en) monitor();
    prev_busreq_n = busreq_n;
    prev_gnt      = gnt;
    if (auto_ack && (busack_n != busreq_n)) begin
      if (ack_wait == 0) begin
        busack_n = busreq_n;
        ack_wait = $urandom_range(ack_rmax);
      end else begin
        ack_wait--;
      end
    end
  endtask

  task automatic wait_busreq(input logic val, input int max);
    int n = 0;
    while (busreq_n !== val && n < max) begin cyc(); n++; end
    if (busreq_n !== val) check("timeout_busreq", busreq_n, val);
  endtask

  task automatic wait_gnt_any(input int max);
    int n = 0;
    while (gnt == 2'b00 && n < max) begin cyc(); n++; end
    if (gnt == 2'b00) check("timeout_gnt", 0, 1);
  endtask

  task automatic wait_gnt_zero(input int max);
    int n = 0;
    while (gnt != 2'b00 && n < max) begin cyc(); n++; end
    if (gnt != 2'b00) check("timeout_gnt_drop", gnt, 0);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin cyc(); n++; end
    if (busy !== 1'b0) check("timeout_idle", busy, 0);
  endtask

  typedef struct {
    logic [1:0] rq;
    logic [1:0] mask;
    logic [1:0] exp_id;
    logic [1:0] exp_gnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    int herr;
    bit gseen;
    int rate;

    // Round-robin sequence from reset (last owner = 1)
    vecs[0] = '{2'b01, 2'b11, 2'd0, 2'b01};
    vecs[1] = '{2'b01, 2'b11, 2'd0, 2'b01};
    vecs[2] = '{2'b11, 2'b11, 2'd1, 2'b10};
    vecs[3] = '{2'b11, 2'b11, 2'd0, 2'b01};
    vecs[4] = '{2'b10, 2'b11, 2'd1, 2'b10};
    vecs[5] = '{2'b11, 2'b01, 2'd0, 2'b01};
    vecs[6] = '{2'b11, 2'b10, 2'd1, 2'b10};
    vecs[7] = '{2'b10, 2'b11, 2'd1, 2'b10};
    vecs[8] = '{2'b11, 2'b11, 2'd0, 2'b01};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busreq_n", busreq_n, 1);
    check("rst_gnt", gnt, 0);
    check("rst_cur_id", cur_id, NREQ - 1);
    check("rst_busy", busy, 0);
    check("rst_hold_err", hold_err, 0);
    check("rst_ack_err", ack_err, 0);
    reset = 1'b1;
    cyc();

    // Table-driven round-robin transactions
    auto_ack = 1'b1;
    ack_rmax = 2;
    for (int i = 0; i < 9; i++) begin
      req     = vecs[i].rq;
      en_mask = vecs[i].mask;
      wait_busreq(1'b0, 40);
      check($sformatf("vec%0d_cur_id", i), cur_id, vecs[i].exp_id);
      wait_gnt_any(20);
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].exp_gnt);
      repeat (2) cyc();
      req = 2'b00;
      wait_idle(60);
    end

    // Single request with exact BUSACK-to-grant latency and CPU slot length
    auto_ack = 1'b0;
    en_mask  = 2'b11;
    req      = 2'b01;
    cyc();
    check("t2_busreq_fall", busreq_n, 0);
    repeat (5) cyc();
    busack_n = 1'b0;
    cyc();
    cyc();
    check("t2_gnt_before_sync", gnt, 0);
    cyc();
    check("t2_gnt_3clk", gnt, 2'b01);
    repeat (4) cyc();
    req = 2'b00;
    cyc();
    check("t2_turn_gnt", gnt, 0);
    check("t2_turn_busreq", busreq_n, 0);
    cyc();
    check("t2_gap_busreq", busreq_n, 1);
    busack_n = 1'b1;
    req      = 2'b01;
    n = 0;
    while (busreq_n === 1'b1 && n < 100) begin n++; cyc(); end
    check("t2_cpu_slot_len", n, CPU_SLOT + 1);
    auto_ack = 1'b1;
    ack_rmax = 0;
    wait_gnt_any(20);
    req = 2'b00;
    wait_idle(60);

    // Both masters held: grants alternate, each revoked by the hold limit
    ack_rmax = 1;
    req      = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt_any(60);
      check($sformatf("t3_gnt%0d", k), gnt, (k % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("t3_cur_id%0d", k), cur_id, (k % 2 == 0) ? 1 : 0);
      wait_gnt_zero(250);
    end
    req = 2'b00;
    wait_idle(60);

    // Hold limit: exactly MAX_HOLD cycles of grant, one hold_err pulse
    req = 2'b10;
    wait_gnt_any(40);
    check("t4_gnt", gnt, 2'b10);
    n    = 0;
    herr = 0;
    while (gnt != 2'b00 && n < 400) begin
      n++;
      cyc();
      if (hold_err) herr++;
    end
    req = 2'b00;
    check("t4_hold_len", n, MAX_HOLD);
    check("t4_hold_err_pulses", herr, 1);
    cyc();
    check("t4_hold_err_clear", hold_err, 0);
    wait_idle(60);

    // BUSACK never answers: timeout after ACK_TO cycles, no grant
    auto_ack = 1'b0;
    busack_n = 1'b1;
    req      = 2'b01;
    wait_busreq(1'b0, 40);
    n     = 0;
    gseen = 1'b0;
    while (busreq_n === 1'b0 && n < 1100) begin
      n++;
      cyc();
      if (gnt != 2'b00) gseen = 1'b1;
    end
    check("t5_req_len", n, ACK_TO);
    check("t5_ack_err", ack_err, 1);
    check("t5_no_gnt", gseen, 0);
    req = 2'b00;
    cyc();
    check("t5_ack_err_clear", ack_err, 0);
    wait_idle(60);

    // Mask revokes a grant: TURN then GAP, masked request stays ignored
    auto_ack = 1'b1;
    ack_rmax = 0;
    req      = 2'b01;
    wait_gnt_any(40);
    check("t6_gnt", gnt, 2'b01);
    repeat (3) cyc();
    en_mask = 2'b10;
    cyc();
    check("t6_gnt_drop", gnt, 0);
    check("t6_turn_busreq", busreq_n, 0);
    check("t6_no_hold_err", hold_err, 0);
    cyc();
    check("t6_gap_busreq", busreq_n, 1);
    repeat (40) cyc();
    check("t6_masked_busy", busy, 0);
    check("t6_masked_busreq", busreq_n, 1);
    req     = 2'b00;
    en_mask = 2'b11;
    cyc();

    // Reset in the middle of a grant acts immediately
    req = 2'b10;
    wait_gnt_any(40);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_busreq", busreq_n, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cur_id", cur_id, NREQ - 1);
    req      = 2'b00;
    busack_n = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the rule model
    prev_busreq_n = 1'b1;
    prev_gnt      = 2'b00;
    last_id       = NREQ - 1;
    high_cnt      = 1000;
    grant_len     = 0;
    n_grants      = 0;
    ack_rmax      = 6;
    mon_en        = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      cyc();
      rate = (c < 2000) ? 40 : 400;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(rate - 1) == 0) req[i] = ~req[i];
        if ($urandom_range(199) == 0) en_mask[i] = ~en_mask[i];
      end
    end
    mon_en = 1'b0;
    check("random_progress", n_grants >= 20, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
